// File: rtl/rx_multi_slot_if.sv
// rx_multi_slot_if: link channel, switch and routing-table signals
// of one router input port (master = environment, slave = port).
interface rx_multi_slot_if #(
  parameter int SIZE      = 8,
  parameter int PKT_BITS  = 3,
  parameter int SLOT_BITS = 1,
  parameter int DEST_BITS = 4,
  parameter int PORT_BITS = 8
);
  logic                 ch_req;
  logic [SIZE-1:0]      ch_flit;
  logic                 ch_ack;
  logic                 sw_req;
  logic [PORT_BITS-1:0] sw_chnl;
  logic                 sw_gnt;
  logic [PKT_BITS-1:0]  buf_addr;
  logic [SIZE-1:0]      buf_data;
  logic [DEST_BITS-1:0] table_addr;
  logic [PORT_BITS-1:0] table_data;
  logic [SLOT_BITS:0]   pkt_count;

  modport master (
    output ch_req, ch_flit, sw_gnt,
    output buf_addr, table_data,
    input  ch_ack, sw_req, sw_chnl,
    input  buf_data, table_addr, pkt_count
  );

  modport slave (
    input  ch_req, ch_flit, sw_gnt,
    input  buf_addr, table_data,
    output ch_ack, sw_req, sw_chnl,
    output buf_data, table_addr, pkt_count
  );
endinterface

// File: rtl/rx_multi_slot.sv
// rx_multi_slot: router input port, two-phase flit channel into a
// circular packet slot buffer. Macro RX_SINK_EN drops every packet.
module rx_multi_slot #(
  parameter int ID        = 0,
  parameter int SIZE      = 8,
  parameter int PKT_BITS  = 3,
  parameter int SLOT_BITS = 1,
  parameter int DEST_BITS = 4,
  parameter int PORT_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  rx_multi_slot_if.slave bus
);
  localparam int NFLIT = 1 << PKT_BITS;
  localparam int NSLOT = 1 << SLOT_BITS;
  localparam logic [SLOT_BITS:0] FULL =
    (SLOT_BITS+1)'(NSLOT);
  localparam logic [PKT_BITS-1:0] LAST =
    PKT_BITS'(NFLIT-1);

  if (PKT_BITS < 1 || SLOT_BITS < 1 ||
      DEST_BITS > SIZE-1 || ID < 0) begin : g_bad_cfg
    $error("rx_multi_slot: bad parameters");
  end

  typedef enum logic [1:0] {
    R_IDLE, R_LATCH, R_RC, R_STORE
  } r_state_t;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_SEND
  } s_state_t;

  r_state_t r_q, r_d;
  s_state_t s_q, s_d;

  logic                 req_m;
  logic                 req_s;
  logic                 req_old;
  logic                 pend;
  logic [SIZE-1:0]      flit_q;
  logic [PKT_BITS-1:0]  flit_cnt;
  logic [SLOT_BITS-1:0] wr_slot;
  logic [SLOT_BITS-1:0] rd_slot;
  logic [SLOT_BITS:0]   pkt_cnt;
  logic [PORT_BITS-1:0] port [NSLOT];
  logic [SIZE-1:0]      mem [NSLOT][NFLIT];
  logic                 ack_q;
  logic                 sw_req_q;
  logic [PORT_BITS-1:0] chnl_q;
  logic [DEST_BITS-1:0] taddr_q;

  logic latch_en;
  logic tbl_en;
  logic rc_en;
  logic store_en;
  logic is_last;
  logic cmplt;
  logic start;
  logic grant;
  logic rel_en;

`ifdef RX_SINK_EN
  localparam logic SINK = 1'b1;

  logic [NFLIT*SIZE-1:0] dump;

  // Whole packet, flit 0 first, with the last flit still in flit_q
  always_comb begin
    dump = '0;
    for (int i = 0; i < NFLIT; i++) begin
      dump[(NFLIT-1-i)*SIZE +: SIZE] =
        (i == NFLIT-1) ? flit_q : mem[wr_slot][i];
    end
  end

  // Report each packet as it is thrown away
  always_ff @(posedge clk) begin
    if (reset && store_en && is_last) begin
      $display("rx_multi_slot[%0d]: destroyed packet %h",
               ID, dump);
    end
  end
`else
  localparam logic SINK = 1'b0;
`endif

  assign pend    = req_s != req_old;
  assign is_last = flit_cnt == LAST;
  assign cmplt   = store_en && is_last && !SINK;

  // Receive FSM state register
  always_ff @(posedge clk) begin
    if (!reset) r_q <= R_IDLE;
    else        r_q <= r_d;
  end

  // Receive FSM next state and datapath strobes
  always_comb begin
    r_d      = r_q;
    latch_en = 1'b0;
    tbl_en   = 1'b0;
    rc_en    = 1'b0;
    store_en = 1'b0;
    unique case (r_q)
      R_IDLE: begin
        if (pend && pkt_cnt < FULL) begin
          latch_en = 1'b1;
          r_d      = R_LATCH;
        end
      end
      R_LATCH: begin
        if (flit_q[SIZE-1]) begin
          tbl_en = 1'b1;
          r_d    = R_RC;
        end else begin
          r_d = R_STORE;
        end
      end
      R_RC: begin
        rc_en = 1'b1;
        r_d   = R_STORE;
      end
      R_STORE: begin
        store_en = 1'b1;
        r_d      = R_IDLE;
      end
      default: r_d = R_IDLE;
    endcase
  end

  // Send FSM state register
  always_ff @(posedge clk) begin
    if (!reset) s_q <= S_IDLE;
    else        s_q <= s_d;
  end

  // Send FSM next state and switch strobes
  always_comb begin
    s_d    = s_q;
    start  = 1'b0;
    grant  = 1'b0;
    rel_en = 1'b0;
    unique case (s_q)
      S_IDLE: begin
        if (!SINK && pkt_cnt != '0) begin
          start = 1'b1;
          s_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.sw_gnt) begin
          grant = 1'b1;
          s_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.sw_gnt) begin
          rel_en = 1'b1;
          s_d    = S_IDLE;
        end
      end
      default: s_d = S_IDLE;
    endcase
  end

  // Request synchroniser, flit latch, routing and ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_m    <= 1'b0;
      req_s    <= 1'b0;
      req_old  <= 1'b0;
      flit_q   <= '0;
      taddr_q  <= '0;
      ack_q    <= 1'b0;
      flit_cnt <= '0;
      wr_slot  <= '0;
      for (int i = 0; i < NSLOT; i++) port[i] <= '0;
    end else begin
      req_m <= bus.ch_req;
      req_s <= req_m;
      if (latch_en) begin
        flit_q  <= bus.ch_flit;
        req_old <= req_s;
      end
      if (tbl_en) taddr_q <= flit_q[DEST_BITS-1:0];
      if (rc_en) port[wr_slot] <= bus.table_data;
      if (store_en) begin
        ack_q    <= ~ack_q;
        flit_cnt <= flit_cnt + 1'b1;
      end
      if (cmplt) wr_slot <= wr_slot + 1'b1;
    end
  end

  // Switch request, read slot and held-packet count
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_req_q <= 1'b0;
      chnl_q   <= '0;
      rd_slot  <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (start) begin
        chnl_q   <= port[rd_slot];
        sw_req_q <= 1'b1;
      end
      if (grant) sw_req_q <= 1'b0;
      if (rel_en) rd_slot <= rd_slot + 1'b1;
      unique case ({cmplt, rel_en})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Flit storage; contents survive reset
  always_ff @(posedge clk) begin
    if (reset && store_en) begin
      mem[wr_slot][flit_cnt] <= flit_q;
    end
  end

  assign bus.ch_ack     = ack_q;
  assign bus.sw_req     = sw_req_q;
  assign bus.sw_chnl    = chnl_q;
  assign bus.table_addr = taddr_q;
  assign bus.pkt_count  = pkt_cnt;
  assign bus.buf_data   = mem[rd_slot][bus.buf_addr];
endmodule

// File: doc/rx_multi_slot.md
Name: rx_multi_slot

Overview:
- Next-generation router input port.
- Receives flits over a two-phase req/ack channel and assembles them into packets of 2**PKT_BITS flits.
- Holds up to 2**SLOT_BITS complete packets in a circular slot buffer, so the channel keeps receiving while an earlier packet waits for or holds the switch.
- Sits between the link channel and the crossbar allocator; the routing table is external.

Parameters:
- ID, 0, instance number for debug prints
- SIZE, 8, flit width in bits; bit SIZE-1 is the head marker
- PKT_BITS, 3, log2 of flits per packet
- SLOT_BITS, 1, log2 of packet slots
- DEST_BITS, 4, destination field width (head flit bits DEST_BITS-1:0)
- PORT_BITS, 8, output port code width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ch_req  in  1  two-phase request (asynchronous, synchronised internally)
- ch_flit  in  SIZE  flit data, stable while a request is pending
- ch_ack  out  1  two-phase acknowledge
- sw_req  out  1  switch allocation request
- sw_chnl  out  PORT_BITS  requested output port
- sw_gnt  in  1  grant; held high for the whole transfer
- buf_addr  in  PKT_BITS  flit index into the packet being sent
- buf_data  out  SIZE  mem[rd_slot][buf_addr], combinational
- table_addr  out  DEST_BITS  routing table address
- table_data  in  PORT_BITS  routing table result, valid one cycle after table_addr
- pkt_count  out  SLOT_BITS+1  number of complete packets held

Behaviour:
- Reset (reset==0 at posedge clk):
  - Outputs: ch_ack=0, sw_req=0, sw_chnl=0, table_addr=0, pkt_count=0.
  - Internal: wr_slot=0, rd_slot=0, flit_cnt=0, all slot ports=0, ch_req_old=0, 2-flop synchroniser cleared, both FSMs to idle.
  - Buffer memory is not cleared.
  - Reset mid-packet discards the partial packet and all held packets.
- Request detection: ch_req passes a 2-flop synchroniser to give req_s. A request is pending when req_s != ch_req_old.
- Receive FSM: R_IDLE -> R_LATCH -> (R_RC) -> R_STORE -> R_IDLE.
  - R_IDLE: if a request is pending and pkt_count < 2**SLOT_BITS, latch ch_flit, set ch_req_old=req_s, go to R_LATCH. Otherwise stay (backpressure by withholding ack).
  - R_LATCH: if head, set table_addr = flit[DEST_BITS-1:0] and go to R_RC; else go to R_STORE.
  - R_RC: port[wr_slot] = table_data; go to R_STORE.
  - R_STORE: write mem[wr_slot][flit_cnt]; toggle ch_ack; flit_cnt++ (wraps at 2**PKT_BITS).
  - On the last flit: wr_slot++ (modulo), pkt_count++.
- Minimum per-flit latency: 3 cycles from pending request to ack toggle for body flits, 4 cycles for head flits (excluding the synchroniser).
- Head/body rules:
  - A head flit at a non-zero position updates the slot port but does not restart the count.
  - A body flit at position 0 is stored under the previously held port.
- Send FSM: S_IDLE -> S_WAIT -> S_SEND -> S_IDLE.
  - S_IDLE: if pkt_count > 0, set sw_chnl = port[rd_slot], sw_req=1, go to S_WAIT.
  - S_WAIT: on sw_gnt, sw_req=0, go to S_SEND.
  - S_SEND: on !sw_gnt, rd_slot++ (modulo), pkt_count--, go to S_IDLE.
- Simultaneous packet completion and release in one cycle leaves pkt_count unchanged.
- Full condition: pkt_count == 2**SLOT_BITS. A pending request is not latched until a release occurs; it is latched the cycle after.
- The receive and send FSMs run concurrently. The write slot never equals the read slot while the read slot is held.

Optional Feature:
- Macro: RX_SINK_EN.
- Defined:
  - A completed packet is dropped at R_STORE of its last flit: wr_slot and pkt_count are unchanged.
  - A "destroyed packet" $display line is printed with ID and all flits.
  - sw_req stays 0 and the send FSM is inert.
  - Ack timing is identical.
- Undefined: normal forwarding as above.

Test Plan (defaults unless stated):
- Reset: hold reset=0 for 3 cycles -> ch_ack=0, sw_req=0, pkt_count=0, table_addr=0.
- Single packet: send head 0x85 then 7 body flits 0x01..0x07, table_data=0x02 -> table_addr=5; 8 ack toggles; sw_req=1 with sw_chnl=0x02; with grant, buf_addr 0..7 reads 0x85,0x01..0x07; after grant drops, pkt_count=0.
- Slot fill/backpressure: no grant, send 3 packets -> pkt_count=2 after 16 flits; 17th flit gets no ack; grant and release packet 0 -> ack follows and the third packet completes into slot 0.
- Concurrency: release packet 0 in the same cycle packet 1's last flit is stored -> pkt_count stays 1, sw_chnl = port of packet 1.
- Mid-operation reset: assert reset after 4 flits -> all outputs return to reset values; a new 8-flit packet is then assembled cleanly at slot 0.
- RX_SINK_EN defined: send 2 packets -> 16 ack toggles, sw_req never 1, pkt_count stays 0, 2 "destroyed packet" messages.
